// File: rtl/idm_arb_pkg.sv
// ============================================================================
// idm_arb_pkg : shared types and default widths for the IDM arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package idm_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Identifies which port owns the IDM read that returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/idm_starve_cnt.sv
// ============================================================================
// idm_starve_cnt : saturating count of consecutive denied fetch cycles
// Revision       : 1.0
// ============================================================================
`default_nettype none

module idm_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_l,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/idm_arbiter.sv
// ============================================================================
// idm_arbiter : shares the single IDM port between fetch and load/store
// Revision    : 1.0
// ============================================================================
`default_nettype none

module idm_arbiter
  import idm_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] idm_in_rwa,
  output logic [DATA_W-1:0] idm_in_wd,
  output logic              idm_in_we,
  output logic              idm_in_re,
  input  logic [DATA_W-1:0] idm_out_rd
);

  owner_e            own_q, own_d;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              force_if;
  logic              starve_inc;

  idm_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_l (rst_l),
    .inc_i (starve_inc),
    .clr_i (!starve_inc),
    .sat_o (force_if)
  );

  assign starve_inc = if_req && !if_gnt;

  // Grants are qualified by rst_l so the IDM port stays quiet during reset.
  always_comb begin
    if_gnt     = 1'b0;
    mem_gnt    = 1'b0;
    idm_in_rwa = '0;
    idm_in_wd  = '0;
    idm_in_we  = 1'b0;
    idm_in_re  = 1'b0;
    own_d      = OWN_NONE;
    if (rst_l) begin
      if (force_if && if_req) begin
        if_gnt = 1'b1;
      end else if (mem_req) begin
        mem_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
    if (if_gnt) begin
      idm_in_rwa = if_addr;
      idm_in_re  = 1'b1;
      own_d      = OWN_IF;
    end else if (mem_gnt) begin
      idm_in_rwa = mem_addr;
      idm_in_wd  = mem_wdata;
      idm_in_we  = mem_we;
      idm_in_re  = !mem_we;
      own_d      = mem_we ? OWN_NONE : OWN_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  // Returning data is bypassed straight through and also captured for holding.
  assign if_rvalid  = (own_q == OWN_IF) && !if_flush;
  assign mem_rvalid = (own_q == OWN_MEM);
  assign if_rdata   = if_rvalid  ? idm_out_rd : if_rdata_q;
  assign mem_rdata  = mem_rvalid ? idm_out_rd : mem_rdata_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (if_rvalid) begin
        if_rdata_q <= idm_out_rd;
      end
      if (mem_rvalid) begin
        mem_rdata_q <= idm_out_rd;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_idm_arbiter.sv
// ============================================================================
// tb_idm_arbiter : directed self-checking bench with a behavioural IDM model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_idm_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_l;
  logic              if_req, if_flush, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] idm_in_rwa;
  logic [DATA_W-1:0] idm_in_wd, idm_out_rd;
  logic              idm_in_we, idm_in_re;

  logic [DATA_W-1:0] idm [0:1023];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  idm_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .idm_in_rwa (idm_in_rwa),
    .idm_in_wd  (idm_in_wd),
    .idm_in_we  (idm_in_we),
    .idm_in_re  (idm_in_re),
    .idm_out_rd (idm_out_rd)
  );

  // Synchronous-read memory
  always @(posedge clk) begin
    if (idm_in_we) idm[idm_in_rwa] <= idm_in_wd;
    if (idm_in_re) idm_out_rd <= idm[idm_in_rwa];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) idm[i] = '0;
    idm[10'h010] = 32'h2402_0005;
    idm[10'h020] = 32'h1111_2222;
    idm_out_rd = '0;
    rst_l = 1'b0;
    if_req = 1'b1; if_addr = 10'h010; if_flush = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h3FF; mem_wdata = '0;

    // Reset: requests present but everything must stay quiet
    @(negedge clk);
    check_val("rst_if_gnt",  32'(if_gnt),    32'd0);
    check_val("rst_mem_gnt", 32'(mem_gnt),   32'd0);
    check_val("rst_re",      32'(idm_in_re), 32'd0);
    check_val("rst_we",      32'(idm_in_we), 32'd0);
    check_val("rst_rwa",     32'(idm_in_rwa), 32'd0);
    check_val("rst_if_rdata",  if_rdata,  32'd0);
    check_val("rst_mem_rdata", mem_rdata, 32'd0);
    next_cycle();
    rst_l = 1'b1; if_req = 1'b0; mem_req = 1'b0;

    // Lone fetch
    next_cycle();
    if_req = 1'b1; if_addr = 10'h010;
    @(negedge clk);
    check_val("f_if_gnt",  32'(if_gnt),     32'd1);
    check_val("f_mem_gnt", 32'(mem_gnt),    32'd0);
    check_val("f_re",      32'(idm_in_re),  32'd1);
    check_val("f_rwa",     32'(idm_in_rwa), 32'h010);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check_val("f_if_rvalid",  32'(if_rvalid),  32'd1);
    check_val("f_if_rdata",   if_rdata,        32'h2402_0005);
    check_val("f_mem_rvalid", 32'(mem_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_val("f_idle_rvalid", 32'(if_rvalid), 32'd0);
    check_val("f_hold_rdata",  if_rdata,       32'h2402_0005);

    // Write then read the same address
    next_cycle();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'h3FF; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_val("w_mem_gnt", 32'(mem_gnt),   32'd1);
    check_val("w_we",      32'(idm_in_we), 32'd1);
    check_val("w_re",      32'(idm_in_re), 32'd0);
    next_cycle();
    mem_we = 1'b0; mem_wdata = '0;
    @(negedge clk);
    check_val("r_mem_gnt",     32'(mem_gnt),    32'd1);
    check_val("r_re",          32'(idm_in_re),  32'd1);
    check_val("w_no_rvalid",   32'(mem_rvalid), 32'd0);
    next_cycle();
    mem_req = 1'b0;
    @(negedge clk);
    check_val("r_mem_rvalid", 32'(mem_rvalid), 32'd1);
    check_val("r_mem_rdata",  mem_rdata,       32'hDEAD_BEEF);

    // Contention: MEM wins four cycles, then fetch is forced once
    next_cycle();
    if_req = 1'b1; if_addr = 10'h010; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h3FF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_val($sformatf("c%0d_if_gnt", c),  32'(if_gnt),  (c == 4) ? 32'd1 : 32'd0);
      check_val($sformatf("c%0d_mem_gnt", c), 32'(mem_gnt), (c == 4) ? 32'd0 : 32'd1);
      if (c == 5) begin
        check_val("il_if_rvalid", 32'(if_rvalid), 32'd1);
        check_val("il_if_rdata",  if_rdata,       32'h2402_0005);
      end
      next_cycle();
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check_val("il_mem_rvalid", 32'(mem_rvalid), 32'd1);
    check_val("il_mem_rdata",  mem_rdata,       32'hDEAD_BEEF);
    check_val("il_if_quiet",   32'(if_rvalid),  32'd0);

    // Flush drops the returning fetch data
    next_cycle();
    if_req = 1'b1; if_addr = 10'h020;
    @(negedge clk);
    check_val("fl_if_gnt", 32'(if_gnt), 32'd1);
    next_cycle();
    if_req = 1'b0; if_flush = 1'b1;
    @(negedge clk);
    check_val("fl_if_rvalid", 32'(if_rvalid), 32'd0);
    check_val("fl_if_rdata",  if_rdata,       32'h2402_0005);
    next_cycle();
    if_req = 1'b1;
    @(negedge clk);
    check_val("fl_gnt_unaffected", 32'(if_gnt), 32'd1);
    next_cycle();
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk);
    check_val("fl2_if_rvalid", 32'(if_rvalid), 32'd1);
    check_val("fl2_if_rdata",  if_rdata,       32'h1111_2222);

    // Reset while a MEM read is in flight
    next_cycle();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h3FF;
    @(negedge clk);
    check_val("rr_mem_gnt", 32'(mem_gnt), 32'd1);
    next_cycle();
    rst_l = 1'b0;
    @(negedge clk);
    check_val("rr_mem_rvalid", 32'(mem_rvalid), 32'd0);
    check_val("rr_mem_gnt0",   32'(mem_gnt),    32'd0);
    check_val("rr_re0",        32'(idm_in_re),  32'd0);
    check_val("rr_mem_rdata",  mem_rdata,       32'd0);
    check_val("rr_if_rdata",   if_rdata,        32'd0);
    next_cycle();
    mem_req = 1'b0;
    rst_l = 1'b1;
    @(negedge clk);
    check_val("rr_post_mem_rvalid", 32'(mem_rvalid), 32'd0);
    check_val("rr_post_if_rvalid",  32'(if_rvalid),  32'd0);
    next_cycle();
    @(negedge clk);
    check_val("rr_idle_mem_rvalid", 32'(mem_rvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
